// File: rtl/htif_mailbox_if.sv
// CPU-side request/response bus into the host-target mailbox.
// One request per accept; exactly one response strobe follows a cycle later.
interface htif_mailbox_if;
  logic        req_valid;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/htif_mailbox.sv
// tohost/fromhost mailbox: decodes test exit, console putchar and unknown
// commands written by the target, and forces a timeout after MAX_CYCLES.
module htif_mailbox #(
  parameter int unsigned MAX_CYCLES = 100000,
  parameter logic [31:0] ACK_WORD   = 32'h0101_0001
) (
  input  logic                 clk,
  input  logic                 nrst,
  htif_mailbox_if.slave        bus,
  output logic                 cons_valid,
  output logic [7:0]           cons_data,
  input  logic                 cons_ready,
  output logic                 test_done,
  output logic                 test_pass,
  output logic [30:0]          fail_code,
  output logic                 timeout,
  output logic                 unknown_cmd
);
  typedef enum logic [2:0] {IDLE, DECODE, CONSOLE, ACK, DONE} state_t;

  localparam logic [31:0] TMO_AT = MAX_CYCLES - 1;

  state_t      state, state_nxt;
  logic [31:0] tohost, fromhost, cyc_cnt, rdata_q, rd_word;
  logic [31:0] tohost_mrg, fromhost_mrg;
  logic        resp_pend, accept, wr_en, wr_to, wr_from, tmo_hit;
  logic        unused_addr_lsb;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign unused_addr_lsb = ^bus.req_addr[1:0];

  assign accept       = bus.req_valid && bus.req_ready;
  // DONE still answers writes but must not let them touch the registers
  assign wr_en        = accept && bus.req_write && (state == IDLE);
  assign wr_to        = wr_en && (bus.req_addr[3:2] == 2'd0);
  assign wr_from      = wr_en && (bus.req_addr[3:2] == 2'd2);
  assign tohost_mrg   = merge(tohost, bus.req_wdata, bus.req_wstrb);
  assign fromhost_mrg = merge(fromhost, bus.req_wdata, bus.req_wstrb);
  assign tmo_hit      = (MAX_CYCLES != 0) && !test_done && (cyc_cnt == TMO_AT);

  always_comb begin
    rd_word = '0;
    case (bus.req_addr[3:2])
      2'd0:    rd_word = tohost;
      2'd2:    rd_word = fromhost;
      default: rd_word = '0;
    endcase
  end

  assign bus.resp_valid = resp_pend;
  assign bus.resp_rdata = resp_pend ? rdata_q : '0;

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    cons_valid    = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (wr_to && (tohost_mrg != '0)) state_nxt = DECODE;
      end
      DECODE: begin
        if (tohost[0])                     state_nxt = DONE;
        else if (tohost[31:16] == 16'h0101) state_nxt = CONSOLE;
        else                               state_nxt = IDLE;
      end
      CONSOLE: begin
        cons_valid = 1'b1;
        if (cons_ready) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      DONE:    bus.req_ready = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (tmo_hit) state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      tohost      <= '0;
      fromhost    <= '0;
      cyc_cnt     <= '0;
      rdata_q     <= '0;
      resp_pend   <= 1'b0;
      cons_data   <= '0;
      test_done   <= 1'b0;
      test_pass   <= 1'b0;
      fail_code   <= '0;
      timeout     <= 1'b0;
      unknown_cmd <= 1'b0;
    end else begin
      resp_pend   <= accept;
      unknown_cmd <= 1'b0;
      if (accept)  rdata_q  <= bus.req_write ? '0 : rd_word;
      if (wr_to)   tohost   <= tohost_mrg;
      if (wr_from) fromhost <= fromhost_mrg;
      if (!test_done && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + 32'd1;
      // a timeout landing on the decode cycle overrides the exit verdict
      if (tmo_hit) begin
        timeout   <= 1'b1;
        test_done <= 1'b1;
        test_pass <= 1'b0;
        fail_code <= '0;
      end else begin
        case (state)
          DECODE: begin
            if (tohost[0]) begin
              test_done <= 1'b1;
              test_pass <= (tohost == 32'd1);
              fail_code <= (tohost == 32'd1) ? 31'd0 : tohost[31:1];
            end else if (tohost[31:16] == 16'h0101) begin
              cons_data <= tohost[7:0];
            end else begin
              unknown_cmd <= 1'b1;
              tohost      <= '0;
            end
          end
          ACK: begin
            tohost   <= '0;
            fromhost <= ACK_WORD;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
